// File: rtl/jk_pkg.sv
// Shared types for the JK flip-flop bank: cell mode encoding.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK = 2'b00,
    JK_MODE_SR = 2'b01,
    JK_MODE_T  = 2'b10,
    JK_MODE_D  = 2'b11
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// One-bit next-state function for a bank cell; purely combinational.
module jk_cell
  import jk_pkg::*;
(
  input  jk_mode_t i_mode,
  input  logic     i_j,
  input  logic     i_k,
  input  logic     i_q,
  output logic     o_q_next,
  output logic     o_sr_viol
);

  always_comb begin
    o_q_next  = i_q;
    o_sr_viol = 1'b0;
    case (i_mode)
      JK_MODE_JK: begin
        case ({i_j, i_k})
          2'b01:   o_q_next = 1'b0;
          2'b10:   o_q_next = 1'b1;
          2'b11:   o_q_next = ~i_q;
          default: o_q_next = i_q;
        endcase
      end
      JK_MODE_SR: begin
        // S=R=1 is illegal: hold the bit and report it upstream
        case ({i_j, i_k})
          2'b01:   o_q_next = 1'b0;
          2'b10:   o_q_next = 1'b1;
          2'b11:   o_sr_viol = 1'b1;
          default: o_q_next = i_q;
        endcase
      end
      JK_MODE_T: o_q_next = i_j ? ~i_q : i_q;
      JK_MODE_D: o_q_next = i_j;
      default:   o_q_next = i_q;
    endcase
  end

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-bit edge-triggered JK/SR/T/D register bank with load path,
// change flags, sticky SR-violation flag and saturating change counter.
module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic [WIDTH-1:0]  changed,
  output logic              sr_err,
  output logic [CNT_W-1:0]  evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_changed;
  logic             r_sr_err;
  logic [CNT_W-1:0] r_evt_cnt;

  logic [WIDTH-1:0] w_cell_next;
  logic [WIDTH-1:0] w_cell_viol;
  logic [WIDTH-1:0] w_q_next;
  logic             w_sr_set;
  jk_mode_t         w_mode;

  assign w_mode = jk_mode_t'(mode);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .i_mode    (w_mode),
      .i_j       (j[gi]),
      .i_k       (k[gi]),
      .i_q       (r_q[gi]),
      .o_q_next  (w_cell_next[gi]),
      .o_sr_viol (w_cell_viol[gi])
    );
  end

  // Load beats update; a violation only counts when the cells actually update
  always_comb begin
    w_q_next = r_q;
    w_sr_set = 1'b0;
    if (load) begin
      w_q_next = load_val;
    end else if (en) begin
      w_q_next = w_cell_next;
      w_sr_set = |w_cell_viol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= RESET_VAL;
      r_changed <= '0;
      r_sr_err  <= 1'b0;
      r_evt_cnt <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
      if (clr) begin
        r_sr_err  <= 1'b0;
        r_evt_cnt <= '0;
      end else begin
        if (w_sr_set)
          r_sr_err <= 1'b1;
        if ((w_q_next != r_q) && (r_evt_cnt != CNT_MAX))
          r_evt_cnt <= r_evt_cnt + 1'b1;
      end
    end
  end

  assign q       = r_q;
  assign qn      = ~r_q;
  assign changed = r_changed;
  assign sr_err  = r_sr_err;
  assign evt_cnt = r_evt_cnt;

endmodule
